inst_rom_arbiter: RTL and testbench

- Shares the single-port instruction ROM between two read requesters: the CPU fetch port, and a debug/boot-loader read port used for ROM inspection and checksum.
- Sits between the processor core and the instruction ROM inside the minimal SOPC top level. Drives the ROM chip-enable and address, and returns registered read data to whichever requester was granted.
- Fixed priority with starvation guard by default; round-robin as a compile option.

---
 rtl/inst_rom_arbiter.sv | 117 +++++++++++
 tb/tb_inst_rom_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Two-requester read arbiter in front of a single-port instruction ROM.
// Fixed priority with a debug starvation guard; define ARB_RR_EN for round-robin.
module inst_rom_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    // Handshake: a requester holds req and addr steady until its gnt is seen
    // high in the same cycle; the read data then returns with a one-cycle
    // rvalid pulse exactly two cycles after that grant.

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0] state;
    logic       owner_dbg;
    logic       accept;
    logic       pick_dbg;
    logic       any_gnt;

    assign accept = (state == ST_IDLE) || (state == ST_RESP);

`ifdef ARB_RR_EN
    // last_gnt_dbg=1 means the debug port received the most recent grant.
    logic last_gnt_dbg;

    assign pick_dbg = dbg_req_i && (!cpu_req_i || !last_gnt_dbg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_dbg <= 1'b1;
        end else if (any_gnt) begin
            last_gnt_dbg <= pick_dbg;
        end
    end
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    assign pick_dbg = dbg_req_i && (!cpu_req_i || (starve_cnt == LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 8'd0;
        end else if (!dbg_req_i || dbg_gnt_o) begin
            starve_cnt <= 8'd0;
        end else if (cpu_gnt_o && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`endif

    assign cpu_gnt_o   = accept && cpu_req_i && !pick_dbg;
    assign dbg_gnt_o   = accept && pick_dbg;
    assign any_gnt     = cpu_gnt_o || dbg_gnt_o;
    assign cpu_stall_o = cpu_req_i && !cpu_gnt_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rom_ce_o   <= 1'b0;
            rom_addr_o <= '0;
            owner_dbg  <= 1'b0;
        end else begin
            rom_ce_o <= any_gnt;
            if (any_gnt) begin
                state      <= ST_ACCESS;
                rom_addr_o <= dbg_gnt_o ? dbg_addr_i : cpu_addr_i;
                owner_dbg  <= dbg_gnt_o;
            end else if (state == ST_ACCESS) begin
                state <= ST_RESP;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Data is captured at the end of ACCESS, so rvalid lines up with RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid_o <= 1'b0;
            dbg_rvalid_o <= 1'b0;
            cpu_rdata_o  <= '0;
            dbg_rdata_o  <= '0;
        end else begin
            cpu_rvalid_o <= (state == ST_ACCESS) && !owner_dbg;
            dbg_rvalid_o <= (state == ST_ACCESS) && owner_dbg;
            if ((state == ST_ACCESS) && !owner_dbg) begin
                cpu_rdata_o <= rom_data_i;
            end
            if ((state == ST_ACCESS) && owner_dbg) begin
                dbg_rdata_o <= rom_data_i;
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter; define ARB_RR_EN to exercise the round-robin build.
module tb_inst_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_gnt_o;
    logic        cpu_stall_o;
    logic        cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        dbg_req_i;
    logic [31:0] dbg_addr_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;

    int checks = 0;
    int errors = 0;

    inst_rom_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_gnt_o   (cpu_gnt_o),
        .cpu_stall_o (cpu_stall_o),
        .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o (cpu_rdata_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_gnt_o   (dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o (dbg_rdata_o),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i)
    );

    // ROM model: data is a fixed function of the address.
    assign rom_data_i = rom_addr_o ^ 32'hA5A5_0000;

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are applied here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] dbg_win;
        logic       prev_dbg;
        logic       cur_dbg;

        cpu_req_i  = 1'b0;
        cpu_addr_i = 32'h0;
        dbg_req_i  = 1'b0;
        dbg_addr_i = 32'h0;
        rst        = 1'b0;
        #2;
        check("rst_ce", {31'b0, rom_ce_o}, 32'd0);
        check("rst_addr", rom_addr_o, 32'd0);
        check("rst_cpu_rvalid", {31'b0, cpu_rvalid_o}, 32'd0);
        check("rst_dbg_rvalid", {31'b0, dbg_rvalid_o}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        check("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Test 1: single CPU read of address 4
        cpu_req_i = 1'b1; cpu_addr_i = 32'h4; #1;
        check("t1_gnt_c1", {31'b0, cpu_gnt_o}, 32'd1);
        check("t1_dbg_gnt_c1", {31'b0, dbg_gnt_o}, 32'd0);
        step();
        cpu_req_i = 1'b0; #1;
        check("t1_ce_c2", {31'b0, rom_ce_o}, 32'd1);
        check("t1_addr_c2", rom_addr_o, 32'h4);
        check("t1_rvalid_c2", {31'b0, cpu_rvalid_o}, 32'd0);
        step();
        check("t1_rvalid_c3", {31'b0, cpu_rvalid_o}, 32'd1);
        check("t1_rdata_c3", cpu_rdata_o, 32'hA5A5_0004);
        check("t1_dbg_rvalid_c3", {31'b0, dbg_rvalid_o}, 32'd0);
        check("t1_ce_c3", {31'b0, rom_ce_o}, 32'd0);
        step();
        check("t1_rvalid_c4", {31'b0, cpu_rvalid_o}, 32'd0);
        check("t1_rdata_hold", cpu_rdata_o, 32'hA5A5_0004);
        check("t1_dbg_rdata_c4", dbg_rdata_o, 32'd0);

        // Test 2: streaming CPU reads 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            cpu_req_i = 1'b1; cpu_addr_i = 32'(4 * i); #1;
            check("t2_gnt", {31'b0, cpu_gnt_o}, 32'd1);
            check("t2_rvalid", {31'b0, cpu_rvalid_o}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("t2_rdata", cpu_rdata_o, 32'(4 * (i - 1)) ^ 32'hA5A5_0000);
            step();
            check("t2_stall", {31'b0, cpu_stall_o}, 32'd1);
            check("t2_gnt_access", {31'b0, cpu_gnt_o}, 32'd0);
            check("t2_rom_addr", rom_addr_o, 32'(4 * i));
            check("t2_ce", {31'b0, rom_ce_o}, 32'd1);
            if (i == 3) cpu_req_i = 1'b0;
            step();
        end
        check("t2_rvalid_last", {31'b0, cpu_rvalid_o}, 32'd1);
        check("t2_rdata_last", cpu_rdata_o, 32'hA5A5_000C);
        check("t2_dbg_rvalid", {31'b0, dbg_rvalid_o}, 32'd0);
        step();

        // Test 3/4: both requesters held continuously from reset
`ifdef ARB_RR_EN
        dbg_win = 8'b1010_1010;
`else
        dbg_win = 8'b1000_1000;
`endif
        do_reset();
        cpu_req_i = 1'b1; cpu_addr_i = 32'h100;
        dbg_req_i = 1'b1; dbg_addr_i = 32'h200;
        prev_dbg = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            cur_dbg = dbg_win[k];
            check("arb_cpu_gnt", {31'b0, cpu_gnt_o}, {31'b0, !cur_dbg});
            check("arb_dbg_gnt", {31'b0, dbg_gnt_o}, {31'b0, cur_dbg});
            check("arb_stall", {31'b0, cpu_stall_o}, {31'b0, cur_dbg});
            if (k > 0) begin
                check("arb_cpu_rvalid", {31'b0, cpu_rvalid_o}, {31'b0, !prev_dbg});
                check("arb_dbg_rvalid", {31'b0, dbg_rvalid_o}, {31'b0, prev_dbg});
                if (prev_dbg) check("arb_dbg_rdata", dbg_rdata_o, 32'hA5A5_0200);
                else          check("arb_cpu_rdata", cpu_rdata_o, 32'hA5A5_0100);
            end
            step();
            check("arb_no_gnt_access", {30'b0, cpu_gnt_o, dbg_gnt_o}, 32'd0);
            check("arb_rom_addr", rom_addr_o, cur_dbg ? 32'h200 : 32'h100);
            if (k == 7) begin
                cpu_req_i = 1'b0;
                dbg_req_i = 1'b0;
            end
            step();
            prev_dbg = cur_dbg;
        end
        check("arb_dbg_rvalid_last", {31'b0, dbg_rvalid_o}, 32'd1);
        check("arb_cpu_rvalid_last", {31'b0, cpu_rvalid_o}, 32'd0);
        step();

        // Test 5: reset during ACCESS
        cpu_req_i = 1'b1; cpu_addr_i = 32'h20; #1;
        check("t5_gnt", {31'b0, cpu_gnt_o}, 32'd1);
        step();
        cpu_req_i = 1'b0;
        check("t5_ce_before", {31'b0, rom_ce_o}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_ce_async", {31'b0, rom_ce_o}, 32'd0);
        check("t5_addr_async", rom_addr_o, 32'd0);
        check("t5_cpu_rdata", cpu_rdata_o, 32'd0);
        step();
        check("t5_rvalid_in_rst", {31'b0, cpu_rvalid_o}, 32'd0);
        check("t5_ce_in_rst", {31'b0, rom_ce_o}, 32'd0);
        step();
        rst = 1'b1;
        step();
        check("t5_rvalid_after", {31'b0, cpu_rvalid_o}, 32'd0);
        check("t5_ce_after", {31'b0, rom_ce_o}, 32'd0);
        check("t5_rdata_after", cpu_rdata_o, 32'd0);

        // Test 6: debug request withdrawn while a CPU read is in ACCESS
        cpu_req_i = 1'b1; cpu_addr_i = 32'h40; #1;
        check("t6_cpu_gnt", {31'b0, cpu_gnt_o}, 32'd1);
        step();
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b1; dbg_addr_i = 32'h300; #1;
        check("t6_dbg_gnt_access", {31'b0, dbg_gnt_o}, 32'd0);
        step();
        dbg_req_i = 1'b0; #1;
        check("t6_cpu_rvalid", {31'b0, cpu_rvalid_o}, 32'd1);
        check("t6_cpu_rdata", cpu_rdata_o, 32'hA5A5_0040);
        check("t6_dbg_gnt_resp", {31'b0, dbg_gnt_o}, 32'd0);
        step();
        check("t6_dbg_rvalid", {31'b0, dbg_rvalid_o}, 32'd0);
        check("t6_ce", {31'b0, rom_ce_o}, 32'd0);
        step();
        check("t6_dbg_rvalid2", {31'b0, dbg_rvalid_o}, 32'd0);
        check("t6_dbg_rdata", dbg_rdata_o, 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
